// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT engine parameters, the twiddle sequencer state type and
// the twiddle ROM address rule. The tw_addr function is also used by the
// butterfly address generator, so both sides agree on which twiddle belongs to
// which (stage, butterfly) pair.
package fft_pkg;

    localparam int LOG2N   = 10;
    localparam int N       = 1 << LOG2N;
    localparam int ADDR_W  = LOG2N - 1;
    localparam int DATA_W  = 16;
    localparam int STAGE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } tw_state_t;

    // Twiddle ROM address for butterfly b of stage s:
    //   (b & (2^s - 1)) << (LOG2N-1-s)
    // Stage 0 masks every bit away, so it always reads W^0 at address 0.
    function automatic logic [ADDR_W-1:0] tw_addr(input logic [STAGE_W-1:0] s,
                                                  input logic [ADDR_W-1:0]  b);
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'((32'd1 << s) - 32'd1);
        return (b & mask) << (ADDR_W - int'(s));
    endfunction

endpackage

// File: rtl/tw_conj_sat.sv
// tw_conj_sat: conditional negate of the twiddle imaginary part, used to
// conjugate twiddles for the inverse transform.
//   conj     in   1       1 = output -img_in, 0 = pass img_in through
//   img_in   in   DATA_W  two's complement Q1.15 imaginary part from the ROM
//   img_out  out  DATA_W  possibly negated value; -1.0 negates to the largest
//                         positive code instead of wrapping back to -1.0
module tw_conj_sat
    import fft_pkg::*;
(
    input  logic              conj,
    input  logic [DATA_W-1:0] img_in,
    output logic [DATA_W-1:0] img_out
);

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    always_comb begin
        img_out = img_in;
        if (conj) begin
            if (img_in == MOST_NEG) begin
                img_out = MOST_POS;
            end else begin
                img_out = ~img_in + 1'b1;
            end
        end
    end

endmodule

// File: rtl/twiddle_seq.sv
// twiddle_seq: read-side sequencer for the twiddle ROM of the radix-2 DIT FFT.
// On start it walks every (stage, butterfly) pair of the transform, drives the
// ROM address and presents each returned twiddle to the butterfly unit over a
// valid/ready stream, optionally conjugated for the inverse FFT.
//   clk, rst               clock, asynchronous active-high reset
//   start, inverse, abort  sequence control (start/inverse sampled in IDLE)
//   busy, done             status: busy for the whole sequence, done pulse at end
//   twiddle_addr           ROM address (ROM has one cycle of read latency)
//   twiddle_real_in/img_in ROM data
//   tw_real, tw_img        twiddle to the butterfly unit
//   tw_valid, tw_ready     stream handshake
//   stage_idx, bfly_idx    tags of the presented pair
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start, ROM address parked at 0
// PRIME  | address of pair (0,0) on the ROM, data not yet available
// STREAM | pair (stage_q, bfly_q) presented, one pair per cycle if ready
module twiddle_seq
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               inverse,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  twiddle_addr,
    input  logic [DATA_W-1:0]  twiddle_real_in,
    input  logic [DATA_W-1:0]  twiddle_img_in,
    output logic [DATA_W-1:0]  tw_real,
    output logic [DATA_W-1:0]  tw_img,
    output logic               tw_valid,
    input  logic               tw_ready,
    output logic [STAGE_W-1:0] stage_idx,
    output logic [ADDR_W-1:0]  bfly_idx
);

    localparam logic [ADDR_W-1:0]  BFLY_LAST  = {ADDR_W{1'b1}};
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);

    tw_state_t          state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [ADDR_W-1:0]  bfly_q, bfly_d;
    logic               inv_q, inv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;

    logic               fire;
    logic               last_pair;
    logic [STAGE_W-1:0] stage_nxt;
    logic [ADDR_W-1:0]  bfly_nxt;
    logic [ADDR_W-1:0]  addr_d;

    assign fire      = valid_q & tw_ready;
    assign last_pair = (stage_q == STAGE_LAST) && (bfly_q == BFLY_LAST);

    // Successor of the current pair. Past the final pair it folds back to
    // (0,0) so the lookahead address never evaluates an out-of-range stage.
    always_comb begin
        stage_nxt = stage_q;
        bfly_nxt  = bfly_q + 1'b1;
        if (bfly_q == BFLY_LAST) begin
            stage_nxt = stage_q + 1'b1;
        end
        if (last_pair) begin
            stage_nxt = '0;
            bfly_nxt  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        inv_d   = inv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        addr_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_PRIME;
                    stage_d = '0;
                    bfly_d  = '0;
                    inv_d   = inverse;
                    busy_d  = 1'b1;
                end
            end
            ST_PRIME: begin
                addr_d  = tw_addr(stage_q, bfly_q);
                state_d = ST_STREAM;
                valid_d = 1'b1;
            end
            ST_STREAM: begin
                // Lookahead: on a fire the ROM must already fetch the next
                // pair so its data lines up with the advanced tags; on a
                // stall the address is held so the ROM output stays put.
                addr_d = fire ? tw_addr(stage_nxt, bfly_nxt) : tw_addr(stage_q, bfly_q);
                if (fire) begin
                    stage_d = stage_nxt;
                    bfly_d  = bfly_nxt;
                    if (last_pair) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything, including completion of the last pair.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            stage_d = '0;
            bfly_d  = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    tw_conj_sat u_conj (
        .conj    (inv_q),
        .img_in  (twiddle_img_in),
        .img_out (tw_img)
    );

    assign tw_real      = twiddle_real_in;
    assign twiddle_addr = addr_d;
    assign busy         = busy_q;
    assign done         = done_q;
    assign tw_valid     = valid_q;
    assign stage_idx    = stage_q;
    assign bfly_idx     = bfly_q;

endmodule

// File: tb/tb_twiddle_seq.sv
// Testbench for twiddle_seq: registered ROM model, pair-by-pair reference
// computed from the address rule with plain arithmetic, randomized ready.
module tb_twiddle_seq;
    import fft_pkg::*;

    localparam int HALF  = N / 2;
    localparam int TOTAL = LOG2N * HALF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               inverse = 1'b0;
    logic               abort = 1'b0;
    logic               tw_ready = 1'b0;
    logic               busy, done, tw_valid;
    logic [ADDR_W-1:0]  twiddle_addr, bfly_idx;
    logic [DATA_W-1:0]  rom_q_re, rom_q_im, tw_real, tw_img;
    logic [STAGE_W-1:0] stage_idx;

    logic [DATA_W-1:0]  rom_re [HALF];
    logic [DATA_W-1:0]  rom_im [HALF];

    int n_vec = 0;
    int n_err = 0;

    twiddle_seq dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .inverse         (inverse),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .twiddle_addr    (twiddle_addr),
        .twiddle_real_in (rom_q_re),
        .twiddle_img_in  (rom_q_im),
        .tw_real         (tw_real),
        .tw_img          (tw_img),
        .tw_valid        (tw_valid),
        .tw_ready        (tw_ready),
        .stage_idx       (stage_idx),
        .bfly_idx        (bfly_idx)
    );

    always #5 clk = ~clk;

    // Twiddle ROM: registered address, data one cycle later.
    always @(posedge clk) begin
        rom_q_re <= rom_re[twiddle_addr];
        rom_q_im <= rom_im[twiddle_addr];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pair k of the transform is stage k/HALF, butterfly k%HALF.
    function automatic int m_addr(input int k);
        int s, b;
        s = k / HALF;
        b = k % HALF;
        return (b % (1 << s)) * (1 << (LOG2N - 1 - s));
    endfunction

    function automatic int m_img(input int a, input bit inv);
        int v;
        v = int'($signed(rom_im[a]));
        if (!inv) return v;
        return (v == -32768) ? 32767 : -v;
    endfunction

    // Called at a negedge with the DUT idle. abort_k < 0 means no abort.
    task automatic run_seq(input bit inv, input int pct, input int abort_k, input bit noise);
        int  k;
        int  cyc;
        bit  rdy;
        k   = 0;
        cyc = 0;
        start = 1'b1; inverse = inv; abort = 1'b0; tw_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("prime_valid", int'(tw_valid), 0);
        chk("prime_busy", int'(busy), 1);
        chk("prime_addr", int'(twiddle_addr), 0);
        @(negedge clk);
        chk("first_valid", int'(tw_valid), 1);
        while (k < TOTAL && cyc < 4 * TOTAL + 100) begin
            if (!tw_valid) begin
                chk("valid_held", int'(tw_valid), 1);
                break;
            end
            chk("stage_idx", int'(stage_idx), k / HALF);
            chk("bfly_idx", int'(bfly_idx), k % HALF);
            chk("tw_real", int'(tw_real), int'(rom_re[m_addr(k)]));
            chk("tw_img", int'($signed(tw_img)), m_img(m_addr(k), inv));
            chk("busy_run", int'(busy), 1);
            chk("done_early", int'(done), 0);
            rdy = ($urandom_range(99) < pct) || (k == abort_k);
            tw_ready = rdy;
            if (noise) begin
                start   = ($urandom_range(19) == 0);
                inverse = 1'($urandom_range(1));
            end
            if (k == abort_k) abort = 1'b1;
            #1;
            if (!rdy) chk("addr_hold", int'(twiddle_addr), m_addr(k));
            else if (k + 1 < TOTAL) chk("addr_next", int'(twiddle_addr), m_addr(k + 1));
            if (k == abort_k) begin
                @(negedge clk);
                abort = 1'b0; tw_ready = 1'b0; start = 1'b0; inverse = 1'b0;
                chk("abort_valid", int'(tw_valid), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_addr", int'(twiddle_addr), 0);
                @(negedge clk);
                chk("abort_nodone", int'(done), 0);
                chk("abort_idle", int'(busy), 0);
                return;
            end
            if (rdy) k++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; tw_ready = 1'b0; inverse = 1'b0;
        chk("pair_count", k, TOTAL);
        if (pct >= 100) chk("cycle_count", cyc, TOTAL);
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 0);
        chk("done_valid", int'(tw_valid), 0);
        @(negedge clk);
        chk("done_single", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_addr", int'(twiddle_addr), 0);
    endtask

    initial begin
        for (int a = 0; a < HALF; a++) begin
            rom_re[a] = DATA_W'(a * 61 + 5);
            rom_im[a] = DATA_W'($urandom);
        end
        rom_im[0]   = 16'h8000;
        rom_im[128] = 16'd1000;

        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(tw_valid), 0);
        chk("rst_addr", int'(twiddle_addr), 0);
        chk("rst_stage", int'(stage_idx), 0);
        chk("rst_bfly", int'(bfly_idx), 0);
        rst = 1'b0;
        @(negedge clk);

        run_seq(1'b0, 100, -1, 1'b0);
        run_seq(1'b0, 30, -1, 1'b0);
        run_seq(1'b1, 100, -1, 1'b0);
        run_seq(1'b0, 70, 3 * HALF + 17, 1'b0);
        run_seq(1'b1, 60, -1, 1'b1);
        run_seq(1'b0, 100, TOTAL - 1, 1'b0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", int'(busy), 0);
        chk("sa_valid", int'(tw_valid), 0);
        @(negedge clk);
        chk("sa_busy2", int'(busy), 0);
        chk("sa_valid2", int'(tw_valid), 0);

        // reset in the middle of a streaming sequence
        start = 1'b1; inverse = 1'b0;
        @(negedge clk);
        start = 1'b0; tw_ready = 1'b1;
        repeat (50) @(negedge clk);
        chk("pre_rst_valid", int'(tw_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(tw_valid), 0);
        chk("mid_rst_addr", int'(twiddle_addr), 0);
        chk("mid_rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0; tw_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_busy", int'(busy), 0);
        end

        run_seq(1'b0, 100, 5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
